// File: rtl/lpddr5_cmd_scheduler_if.sv
// lpddr5_cmd_scheduler_if
// Bundles the signals between lpddr5_cmd_scheduler and its neighbours:
//   in_*       host command handshake (in_valid/in_ready, direction, prio, addr)
//   out_*      issued command handshake towards the controller (out_valid/out_ready)
//   rd_count / wr_count / drain_mode   queue occupancy and mode status
// Modports:
//   master  host/controller side: drives in_* and out_ready
//   slave   scheduler side: drives in_ready, out_*, counts and drain_mode
interface lpddr5_cmd_scheduler_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int PRIORITY_WIDTH = 3,
   parameter int QUEUE_DEPTH    = 8
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic                      in_valid;
   logic                      in_rw;
   logic [PRIORITY_WIDTH-1:0] in_prio;
   logic [ADDR_WIDTH-1:0]     in_addr;
   logic                      in_ready;

   logic                      out_valid;
   logic                      out_rw;
   logic [PRIORITY_WIDTH-1:0] out_prio;
   logic [ADDR_WIDTH-1:0]     out_addr;
   logic                      out_ready;

   logic [CW-1:0]             rd_count;
   logic [CW-1:0]             wr_count;
   logic                      drain_mode;

   modport master (
      output in_valid, in_rw, in_prio, in_addr, out_ready,
      input  in_ready, out_valid, out_rw, out_prio, out_addr,
             rd_count, wr_count, drain_mode
   );

   modport slave (
      input  in_valid, in_rw, in_prio, in_addr, out_ready,
      output in_ready, out_valid, out_rw, out_prio, out_addr,
             rd_count, wr_count, drain_mode
   );
endinterface

// File: rtl/lpddr5_cmd_scheduler.sv
// lpddr5_cmd_scheduler
// Upstream stage of the LPDDR5 controller. Host commands are buffered in a
// read queue and a write queue (QUEUE_DEPTH entries each). Every cycle the
// issue register may load one command chosen by: starvation, then the
// read/write drain mode, then priority, then age, then slot index (read wins
// a full cross-queue tie). The chosen command is held on a registered
// valid/ready output.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    lpddr5_cmd_scheduler_if.slave (host input, issued output, status)
// Optional feature macro: LPDDR5_CMDQ_RAW_HAZARD_EN
//   When defined, a read whose address matches a queued write, or a write
//   held in the issue register, is not eligible for issue.
module lpddr5_cmd_scheduler #(
   parameter int ADDR_WIDTH     = 32,
   parameter int PRIORITY_WIDTH = 3,
   parameter int QUEUE_DEPTH    = 8,
   parameter int WR_HI          = 6,
   parameter int WR_LO          = 2,
   parameter int STARVE_LIMIT   = 15
) (
   input logic                   clk,
   input logic                   rst_n,
   lpddr5_cmd_scheduler_if.slave bus
);
   localparam int IW   = $clog2(QUEUE_DEPTH);
   localparam int CW   = IW + 1;
   localparam int AGEW = $clog2(STARVE_LIMIT + 1);
   localparam int KW   = 1 + 1 + PRIORITY_WIDTH + AGEW + IW + 1;
   localparam logic [AGEW-1:0] AGE_MAX = AGEW'(STARVE_LIMIT);
   localparam logic [CW-1:0]   FULL    = CW'(QUEUE_DEPTH);

   typedef enum logic {READ_MODE = 1'b0, WRITE_DRAIN = 1'b1} mode_t;
   mode_t state_q, state_d;

   logic [QUEUE_DEPTH-1:0]    rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
   logic [PRIORITY_WIDTH-1:0] rd_prio_q [QUEUE_DEPTH], rd_prio_d [QUEUE_DEPTH];
   logic [PRIORITY_WIDTH-1:0] wr_prio_q [QUEUE_DEPTH], wr_prio_d [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0]     rd_addr_q [QUEUE_DEPTH], rd_addr_d [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0]     wr_addr_q [QUEUE_DEPTH], wr_addr_d [QUEUE_DEPTH];
   logic [AGEW-1:0]           rd_age_q  [QUEUE_DEPTH], rd_age_d  [QUEUE_DEPTH];
   logic [AGEW-1:0]           wr_age_q  [QUEUE_DEPTH], wr_age_d  [QUEUE_DEPTH];
   logic [CW-1:0]             rd_count_q, rd_count_d, wr_count_q, wr_count_d;

   logic                      out_valid_q, out_valid_d, out_rw_q, out_rw_d;
   logic [PRIORITY_WIDTH-1:0] out_prio_q, out_prio_d;
   logic [ADDR_WIDTH-1:0]     out_addr_q, out_addr_d;

   logic [QUEUE_DEPTH-1:0]    rd_elig, wr_elig;
   logic                      sel_found, sel_rw;
   logic [IW-1:0]             sel_idx, rd_free_idx, wr_free_idx;
   logic [KW-1:0]             best_key, cand_key;
   logic                      issue, enq_rd, enq_wr, deq_rd, deq_wr;

   assign bus.in_ready   = bus.in_rw ? (wr_count_q != FULL) : (rd_count_q != FULL);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_rw     = out_rw_q;
   assign bus.out_prio   = out_prio_q;
   assign bus.out_addr   = out_addr_q;
   assign bus.rd_count   = rd_count_q;
   assign bus.wr_count   = wr_count_q;
   assign bus.drain_mode = (state_q == WRITE_DRAIN);

   // Eligibility: a read may be held back behind a same-address write so it
   // never overtakes it; starvation does not lift this.
   always_comb begin
      wr_elig = wr_valid_q;
      rd_elig = rd_valid_q;
`ifdef LPDDR5_CMDQ_RAW_HAZARD_EN
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (out_valid_q && out_rw_q && (out_addr_q == rd_addr_q[i]))
            rd_elig[i] = 1'b0;
         for (int j = 0; j < QUEUE_DEPTH; j++) begin
            if (wr_valid_q[j] && (wr_addr_q[j] == rd_addr_q[i]))
               rd_elig[i] = 1'b0;
         end
      end
`endif
   end

   // Selection as a lexicographic maximum over one key per entry:
   // {starved, preferred-queue (non-starved only), prio, age, inverted slot, is_read}.
   // Queue preference is masked for starved entries so two starved entries
   // from different queues fall through to prio/age/slot and finally read-wins.
   always_comb begin
      sel_found = 1'b0;
      sel_rw    = 1'b0;
      sel_idx   = '0;
      best_key  = '0;
      cand_key  = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (rd_elig[i]) begin
            cand_key = {rd_age_q[i] == AGE_MAX,
                        (rd_age_q[i] != AGE_MAX) && (state_q == READ_MODE),
                        rd_prio_q[i], rd_age_q[i], IW'(QUEUE_DEPTH - 1 - i), 1'b1};
            if (!sel_found || (cand_key > best_key)) begin
               sel_found = 1'b1;
               sel_rw    = 1'b0;
               sel_idx   = IW'(i);
               best_key  = cand_key;
            end
         end
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (wr_elig[i]) begin
            cand_key = {wr_age_q[i] == AGE_MAX,
                        (wr_age_q[i] != AGE_MAX) && (state_q == WRITE_DRAIN),
                        wr_prio_q[i], wr_age_q[i], IW'(QUEUE_DEPTH - 1 - i), 1'b0};
            if (!sel_found || (cand_key > best_key)) begin
               sel_found = 1'b1;
               sel_rw    = 1'b1;
               sel_idx   = IW'(i);
               best_key  = cand_key;
            end
         end
      end
   end

   // Lowest free slot per queue, found on the pre-edge state so a slot being
   // vacated this cycle is not reused until the next one.
   always_comb begin
      rd_free_idx = '0;
      wr_free_idx = '0;
      for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
         if (!rd_valid_q[i]) rd_free_idx = IW'(i);
         if (!wr_valid_q[i]) wr_free_idx = IW'(i);
      end
   end

   // Queue and issue-register next state: dequeue, then aging of survivors,
   // then enqueue of the new entry with age 0.
   always_comb begin
      rd_valid_d  = rd_valid_q;
      wr_valid_d  = wr_valid_q;
      rd_prio_d   = rd_prio_q;
      wr_prio_d   = wr_prio_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      rd_age_d    = rd_age_q;
      wr_age_d    = wr_age_q;
      out_valid_d = out_valid_q;
      out_rw_d    = out_rw_q;
      out_prio_d  = out_prio_q;
      out_addr_d  = out_addr_q;

      issue  = !out_valid_q || bus.out_ready;
      deq_rd = issue && sel_found && !sel_rw;
      deq_wr = issue && sel_found && sel_rw;
      enq_rd = bus.in_valid && bus.in_ready && !bus.in_rw;
      enq_wr = bus.in_valid && bus.in_ready && bus.in_rw;

      if (issue) begin
         out_valid_d = sel_found;
         if (sel_found) begin
            out_rw_d = sel_rw;
            if (sel_rw) begin
               out_prio_d          = wr_prio_q[sel_idx];
               out_addr_d          = wr_addr_q[sel_idx];
               wr_valid_d[sel_idx] = 1'b0;
            end else begin
               out_prio_d          = rd_prio_q[sel_idx];
               out_addr_d          = rd_addr_q[sel_idx];
               rd_valid_d[sel_idx] = 1'b0;
            end
         end
      end

      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         if (rd_valid_d[i] && (rd_age_q[i] != AGE_MAX)) rd_age_d[i] = rd_age_q[i] + AGEW'(1);
         if (wr_valid_d[i] && (wr_age_q[i] != AGE_MAX)) wr_age_d[i] = wr_age_q[i] + AGEW'(1);
      end

      if (enq_rd) begin
         rd_valid_d[rd_free_idx] = 1'b1;
         rd_prio_d[rd_free_idx]  = bus.in_prio;
         rd_addr_d[rd_free_idx]  = bus.in_addr;
         rd_age_d[rd_free_idx]   = '0;
      end
      if (enq_wr) begin
         wr_valid_d[wr_free_idx] = 1'b1;
         wr_prio_d[wr_free_idx]  = bus.in_prio;
         wr_addr_d[wr_free_idx]  = bus.in_addr;
         wr_age_d[wr_free_idx]   = '0;
      end

      rd_count_d = rd_count_q + CW'(enq_rd) - CW'(deq_rd);
      wr_count_d = wr_count_q + CW'(enq_wr) - CW'(deq_wr);
   end

   // Drain-mode FSM, driven by the write count after this edge's update.
   always_comb begin
      state_d = state_q;
      case (state_q)
         READ_MODE:   if (wr_count_d >= CW'(WR_HI)) state_d = WRITE_DRAIN;
         WRITE_DRAIN: if (wr_count_d <= CW'(WR_LO)) state_d = READ_MODE;
         default:     state_d = READ_MODE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= READ_MODE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q  <= '0;
         wr_valid_q  <= '0;
         rd_count_q  <= '0;
         wr_count_q  <= '0;
         out_valid_q <= 1'b0;
         out_rw_q    <= 1'b0;
         out_prio_q  <= '0;
         out_addr_q  <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            rd_prio_q[i] <= '0;
            wr_prio_q[i] <= '0;
            rd_addr_q[i] <= '0;
            wr_addr_q[i] <= '0;
            rd_age_q[i]  <= '0;
            wr_age_q[i]  <= '0;
         end
      end else begin
         rd_valid_q  <= rd_valid_d;
         wr_valid_q  <= wr_valid_d;
         rd_count_q  <= rd_count_d;
         wr_count_q  <= wr_count_d;
         out_valid_q <= out_valid_d;
         out_rw_q    <= out_rw_d;
         out_prio_q  <= out_prio_d;
         out_addr_q  <= out_addr_d;
         rd_prio_q   <= rd_prio_d;
         wr_prio_q   <= wr_prio_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         rd_age_q    <= rd_age_d;
         wr_age_q    <= wr_age_d;
      end
   end
endmodule

// File: tb/tb_lpddr5_cmd_scheduler.sv
// tb_lpddr5_cmd_scheduler
// Testbench for lpddr5_cmd_scheduler. A behavioural model holds the pending
// commands as plain slot records and picks the winner with an ordered
// comparison of the selection rules; every command the model issues is pushed
// into a scoreboard queue, and a negedge monitor pops and compares whenever
// the DUT completes an output handshake. Directed phases follow the test
// plan, then a randomized phase runs against the same model.
module tb_lpddr5_cmd_scheduler;
   localparam int AW    = 32;
   localparam int PW    = 3;
   localparam int QD    = 8;
   localparam int WR_HI = 6;
   localparam int WR_LO = 2;
   localparam int LIMIT = 15;
`ifdef LPDDR5_CMDQ_RAW_HAZARD_EN
   localparam bit RAW_EN = 1'b1;
`else
   localparam bit RAW_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lpddr5_cmd_scheduler_if #(.ADDR_WIDTH(AW), .PRIORITY_WIDTH(PW), .QUEUE_DEPTH(QD)) bus();

   lpddr5_cmd_scheduler #(
      .ADDR_WIDTH(AW), .PRIORITY_WIDTH(PW), .QUEUE_DEPTH(QD),
      .WR_HI(WR_HI), .WR_LO(WR_LO), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct { bit vld; int prio; logic [AW-1:0] addr; int age; } slot_t;
   typedef struct { bit rw; int prio; logic [AW-1:0] addr; } cmd_t;
   typedef struct { bit starved; bit pref; int prio; int age; int slot; bit isRead; } cand_t;

   slot_t         rdE[QD];
   slot_t         wrE[QD];
   cmd_t          expQ[$];
   cmd_t          issuedLog[$];
   bit            mOutValid;
   bit            mOutRw;
   logic [AW-1:0] mOutAddr;
   bit            mDrain;
   int            nChecks = 0;
   int            nPass   = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int countValid(input bit isWr);
      int n = 0;
      for (int i = 0; i < QD; i++) if (isWr ? wrE[i].vld : rdE[i].vld) n++;
      return n;
   endfunction

   // Ordered selection rules: starved, preferred queue, prio, age, slot, read.
   function automatic bit better(input cand_t a, input cand_t b);
      if (a.starved != b.starved) return a.starved;
      if (!a.starved && (a.pref != b.pref)) return a.pref;
      if (a.prio != b.prio) return a.prio > b.prio;
      if (a.age != b.age) return a.age > b.age;
      if (a.slot != b.slot) return a.slot < b.slot;
      return a.isRead;
   endfunction

`ifdef LPDDR5_CMDQ_RAW_HAZARD_EN
   function automatic bit readBlocked(input logic [AW-1:0] a);
      if (mOutValid && mOutRw && (mOutAddr == a)) return 1'b1;
      for (int j = 0; j < QD; j++) if (wrE[j].vld && (wrE[j].addr == a)) return 1'b1;
      return 1'b0;
   endfunction
`endif

   task automatic modelReset();
      for (int i = 0; i < QD; i++) begin
         rdE[i].vld = 1'b0;
         wrE[i].vld = 1'b0;
      end
      mOutValid = 1'b0;
      mOutRw    = 1'b0;
      mOutAddr  = '0;
      mDrain    = 1'b0;
      expQ.delete();
   endtask

   task automatic modelStep();
      int    rc, wc, enqSlot;
      bit    rdy, found, load, elig;
      cand_t best, c;
      cmd_t  cmd;
      rc = countValid(1'b0);
      wc = countValid(1'b1);
      rdy = bus.in_rw ? (wc != QD) : (rc != QD);
      enqSlot = -1;
      if (bus.in_valid && rdy) begin
         for (int i = 0; i < QD; i++) begin
            if (enqSlot < 0 && !(bus.in_rw ? wrE[i].vld : rdE[i].vld)) enqSlot = i;
         end
      end
      found = 1'b0;
      best  = '{0, 0, 0, 0, 0, 0};
      for (int i = 0; i < QD; i++) begin
         elig = rdE[i].vld;
`ifdef LPDDR5_CMDQ_RAW_HAZARD_EN
         if (elig && readBlocked(rdE[i].addr)) elig = 1'b0;
`endif
         if (elig) begin
            c = '{rdE[i].age == LIMIT, !mDrain, rdE[i].prio, rdE[i].age, i, 1'b1};
            if (!found || better(c, best)) begin best = c; found = 1'b1; end
         end
      end
      for (int i = 0; i < QD; i++) begin
         if (wrE[i].vld) begin
            c = '{wrE[i].age == LIMIT, mDrain, wrE[i].prio, wrE[i].age, i, 1'b0};
            if (!found || better(c, best)) begin best = c; found = 1'b1; end
         end
      end
      load = !mOutValid || bus.out_ready;
      if (load) begin
         mOutValid = found;
         if (found) begin
            if (best.isRead) begin
               cmd = '{1'b0, rdE[best.slot].prio, rdE[best.slot].addr};
               rdE[best.slot].vld = 1'b0;
            end else begin
               cmd = '{1'b1, wrE[best.slot].prio, wrE[best.slot].addr};
               wrE[best.slot].vld = 1'b0;
            end
            mOutRw   = cmd.rw;
            mOutAddr = cmd.addr;
            expQ.push_back(cmd);
         end
      end
      for (int i = 0; i < QD; i++) begin
         if (rdE[i].vld && rdE[i].age < LIMIT) rdE[i].age++;
         if (wrE[i].vld && wrE[i].age < LIMIT) wrE[i].age++;
      end
      if (enqSlot >= 0) begin
         if (bus.in_rw) wrE[enqSlot] = '{1'b1, int'(bus.in_prio), bus.in_addr, 0};
         else           rdE[enqSlot] = '{1'b1, int'(bus.in_prio), bus.in_addr, 0};
      end
      wc = countValid(1'b1);
      if (!mDrain && wc >= WR_HI) mDrain = 1'b1;
      else if (mDrain && wc <= WR_LO) mDrain = 1'b0;
   endtask

   // Reference model advances on the same edges as the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else        modelStep();
   end

   // Monitor: compares status every cycle and the held command against the
   // scoreboard head; pops when the controller side accepts it.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("out_valid", 64'(bus.out_valid), 64'(mOutValid));
         if (bus.out_valid) begin
            if (expQ.size() == 0) begin
               nChecks++;
               $display("[TB] FAIL sb_unexpected: got out_valid=1 addr=0x%0h required no pending issue", bus.out_addr);
            end else begin
               checkOutput("out_rw",   64'(bus.out_rw),   64'(expQ[0].rw));
               checkOutput("out_prio", 64'(bus.out_prio), 64'(expQ[0].prio));
               checkOutput("out_addr", 64'(bus.out_addr), 64'(expQ[0].addr));
               if (bus.out_ready) void'(expQ.pop_front());
            end
            if (bus.out_ready) issuedLog.push_back('{bus.out_rw, int'(bus.out_prio), bus.out_addr});
         end
         checkOutput("rd_count",   64'(bus.rd_count),   64'(countValid(1'b0)));
         checkOutput("wr_count",   64'(bus.wr_count),   64'(countValid(1'b1)));
         checkOutput("drain_mode", 64'(bus.drain_mode), 64'(mDrain));
         checkOutput("in_ready",   64'(bus.in_ready),
                     64'(bus.in_rw ? (countValid(1'b1) != QD) : (countValid(1'b0) != QD)));
      end
   end

   task automatic applyStimulus(input bit v, input bit rw, input int prio,
                                input logic [AW-1:0] addr, input bit ordy);
      bus.in_valid  = v;
      bus.in_rw     = rw;
      bus.in_prio   = PW'(prio);
      bus.in_addr   = addr;
      bus.out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit ordy);
      repeat (n) applyStimulus(1'b0, 1'b0, 0, '0, ordy);
   endtask

   task automatic checkLog(input string name, input logic [AW-1:0] expAddr[$]);
      checkOutput({name, "_len"}, 64'(issuedLog.size()), 64'(expAddr.size()));
      foreach (expAddr[i]) begin
         if (i < issuedLog.size()) checkOutput(name, 64'(issuedLog[i].addr), 64'(expAddr[i]));
      end
   endtask

   initial begin
      logic [AW-1:0] e[$];
      bit            seen;
      bus.in_valid  = 1'b0;
      bus.in_rw     = 1'b0;
      bus.in_prio   = '0;
      bus.in_addr   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_rw",    64'(bus.out_rw),    64'd0);
      checkOutput("rst_out_prio",  64'(bus.out_prio),  64'd0);
      checkOutput("rst_out_addr",  64'(bus.out_addr),  64'd0);
      checkOutput("rst_rd_count",  64'(bus.rd_count),  64'd0);
      checkOutput("rst_wr_count",  64'(bus.wr_count),  64'd0);
      checkOutput("rst_drain",     64'(bus.drain_mode), 64'd0);
      checkOutput("rst_in_ready_rd", 64'(bus.in_ready), 64'd1);
      bus.in_rw = 1'b1;
      #1;
      checkOutput("rst_in_ready_wr", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2, 1'b1);

      $display("[TB] single read latency");
      applyStimulus(1'b1, 1'b0, 2, 32'h100, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("lat_cycle2_rw",    64'(bus.out_rw),    64'd0);
      checkOutput("lat_cycle2_addr",  64'(bus.out_addr),  64'h100);
      @(posedge clk);
      #1;
      checkOutput("lat_rd_count", 64'(bus.rd_count), 64'd0);
      idle(3, 1'b1);

      $display("[TB] priority and age ordering");
      issuedLog.delete();
      applyStimulus(1'b1, 1'b0, 0, 32'h10, 1'b0);
      applyStimulus(1'b1, 1'b0, 1, 32'h11, 1'b0);
      applyStimulus(1'b1, 1'b0, 5, 32'h15, 1'b0);
      applyStimulus(1'b1, 1'b0, 3, 32'h13, 1'b0);
      idle(5, 1'b0);
      idle(8, 1'b1);
      e = '{32'h10, 32'h15, 32'h13, 32'h11};
      checkLog("prio_order", e);
      issuedLog.delete();
      applyStimulus(1'b1, 1'b0, 0, 32'h30, 1'b0);
      applyStimulus(1'b1, 1'b0, 4, 32'h21, 1'b0);
      applyStimulus(1'b1, 1'b0, 4, 32'h22, 1'b0);
      idle(2, 1'b0);
      idle(6, 1'b1);
      e = '{32'h30, 32'h21, 32'h22};
      checkLog("age_order", e);

      $display("[TB] write fill and drain");
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, i % 8, 32'h400 + 32'(i), 1'b0);
      bus.in_valid = 1'b0;
      bus.in_rw    = 1'b1;
      #1;
      checkOutput("full_in_ready_wr", 64'(bus.in_ready),   64'd0);
      checkOutput("full_wr_count",    64'(bus.wr_count),   64'd8);
      checkOutput("full_drain",       64'(bus.drain_mode), 64'd1);
      bus.in_rw = 1'b0;
      #1;
      checkOutput("full_in_ready_rd", 64'(bus.in_ready), 64'd1);
      idle(20, 1'b1);
      checkOutput("drained_drain", 64'(bus.drain_mode), 64'd0);

      $display("[TB] write starvation");
      issuedLog.delete();
      applyStimulus(1'b1, 1'b0, 7, 32'h600, 1'b0);
      for (int i = 1; i < 4; i++) applyStimulus(1'b1, 1'b0, 7, 32'h600 + 32'(i), 1'b0);
      applyStimulus(1'b1, 1'b1, 0, 32'h500, 1'b0);
      for (int i = 4; i < 34; i++) applyStimulus(1'b1, 1'b0, 7, 32'h600 + 32'(i), 1'b1);
      idle(12, 1'b1);
      seen = 1'b0;
      foreach (issuedLog[i]) if (issuedLog[i].rw && issuedLog[i].addr == 32'h500) seen = 1'b1;
      checkOutput("starve_write_issued", 64'(seen), 64'd1);

      $display("[TB] read after write same address");
      issuedLog.delete();
      applyStimulus(1'b1, 1'b0, 0, 32'h300, 1'b0);
      applyStimulus(1'b1, 1'b1, 0, 32'h200, 1'b0);
      applyStimulus(1'b1, 1'b0, 7, 32'h200, 1'b0);
      idle(3, 1'b0);
      idle(6, 1'b1);
      checkOutput("raw_log_len", 64'(issuedLog.size()), 64'd3);
      if (issuedLog.size() == 3) begin
         checkOutput("raw_second_rw", 64'(issuedLog[1].rw), 64'(RAW_EN));
         checkOutput("raw_third_rw",  64'(issuedLog[2].rw), 64'(!RAW_EN));
      end

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 7)), 32'h200 + 32'(4 * $urandom_range(0, 3)),
                       $urandom_range(0, 3) != 0);
      end
      idle(40, 1'b1);

      $display("[TB] reset during write drain");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1, 32'h700 + 32'(i), 1'b0);
      idle(2, 1'b1);
      checkOutput("pre_rst_drain", 64'(bus.drain_mode), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(bus.out_valid),  64'd0);
      checkOutput("midrst_rd_count",  64'(bus.rd_count),   64'd0);
      checkOutput("midrst_wr_count",  64'(bus.wr_count),   64'd0);
      checkOutput("midrst_drain",     64'(bus.drain_mode), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 7)), 32'h200 + 32'(4 * $urandom_range(0, 3)), 1'b1);
      end
      idle(40, 1'b1);
      checkOutput("final_sb_empty", 64'(expQ.size()), 64'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
